time_set_ctrl: RTL and testbench

Timekeeping and time-setting controller for the four-digit clock display. Keeps hours:minutes in BCD from an internal seconds prescaler and runs a RUN / SET_H / SET_MIN state machine driven by two debounced button pulses. Drives the four digit inputs of the multiplexed display chain, plus a per-digit blank mask that blinks the field being set.

---
 rtl/clock_pkg.sv | 12 +
 rtl/bcd_mod_counter.sv | 54 +++++
 rtl/time_set_ctrl.sv | 100 ++++++++++
 tb/tb_time_set_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared constants for the clock display timekeeping slice
package clock_pkg;
   localparam int DIGIT_W = 4;

   localparam logic [1:0] RUN     = 2'd0;
   localparam logic [1:0] SET_H   = 2'd1;
   localparam logic [1:0] SET_MIN = 2'd2;

   localparam int SEC_MAX = 59;
   localparam int MIN_MAX = 59;
   localparam int HR_MAX  = 23;
endpackage

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit BCD counter wrapping at MAX
module bcd_mod_counter
   import clock_pkg::*;
#(
   parameter int MAX = 59
) (
   input  logic               clk_in,
   input  logic               rst,
   input  logic               inc,
   input  logic               clr,
   output logic [DIGIT_W-1:0] tens_out,
   output logic [DIGIT_W-1:0] units_out,
   output logic               carry_out
);
   localparam logic [DIGIT_W-1:0] MAX_T = DIGIT_W'(MAX / 10);
   localparam logic [DIGIT_W-1:0] MAX_U = DIGIT_W'(MAX % 10);

   logic [DIGIT_W-1:0] tens_q, tens_d, units_q, units_d;
   logic               at_max;

   assign at_max    = (tens_q == MAX_T) && (units_q == MAX_U);
   assign carry_out = inc && at_max;
   assign tens_out  = tens_q;
   assign units_out = units_q;

   always_comb begin
      tens_d  = tens_q;
      units_d = units_q;
      if (clr) begin
         tens_d  = '0;
         units_d = '0;
      end else if (inc) begin
         if (at_max) begin
            tens_d  = '0;
            units_d = '0;
         end else if (units_q == DIGIT_W'(9)) begin
            units_d = '0;
            tens_d  = tens_q + DIGIT_W'(1);
         end else begin
            units_d = units_q + DIGIT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         tens_q  <= '0;
         units_q <= '0;
      end else begin
         tens_q  <= tens_d;
         units_q <= units_d;
      end
   end
endmodule

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - hh:mm timekeeping with RUN/SET_H/SET_MIN setting and blink mask
module time_set_ctrl
   import clock_pkg::*;
#(
   parameter int CLK_DIV = 100
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic [3:0] d0_min_out,
   output logic [3:0] d1_min_out,
   output logic [3:0] d0_h_out,
   output logic [3:0] d1_h_out,
   output logic [3:0] blank,
   output logic [1:0] mode
);
   localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

   logic [1:0]       state_q, state_d;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             sec_tick, blink_phase, run_st, leave_set, inc_ok;
   logic             sec_carry, min_carry;
   logic [7:0]       sec_digits_unused;
   logic             hr_carry_unused;

   assign sec_tick    = (div_cnt_q == DIV_LAST);
   assign blink_phase = (div_cnt_q >= DIV_HALF);
   assign run_st      = (state_q == RUN);
   assign leave_set   = btn_mode && (state_q == SET_MIN);
   // A mode press in the same cycle wins; the increment is dropped.
   assign inc_ok      = btn_inc && !btn_mode;

   always_comb begin
      state_d = state_q;
      if (btn_mode) begin
         case (state_q)
            RUN:     state_d = SET_H;
            SET_H:   state_d = SET_MIN;
            default: state_d = RUN;
         endcase
      end
   end

   // Restarting the prescaler on exit gives a full first minute in RUN.
   assign div_cnt_d = (leave_set || sec_tick) ? '0 : div_cnt_q + 1'b1;

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q   <= RUN;
         div_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         div_cnt_q <= div_cnt_d;
      end
   end

   bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
      .clk_in    (clk_in),
      .rst       (rst),
      .inc       (run_st && sec_tick),
      .clr       (leave_set),
      .tens_out  (sec_digits_unused[7:4]),
      .units_out (sec_digits_unused[3:0]),
      .carry_out (sec_carry)
   );

   bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
      .clk_in    (clk_in),
      .rst       (rst),
      .inc       (sec_carry || ((state_q == SET_MIN) && inc_ok)),
      .clr       (1'b0),
      .tens_out  (d1_min_out),
      .units_out (d0_min_out),
      .carry_out (min_carry)
   );

   bcd_mod_counter #(.MAX(HR_MAX)) u_hr (
      .clk_in    (clk_in),
      .rst       (rst),
      .inc       ((run_st && min_carry) || ((state_q == SET_H) && inc_ok)),
      .clr       (1'b0),
      .tens_out  (d1_h_out),
      .units_out (d0_h_out),
      .carry_out (hr_carry_unused)
   );

   always_comb begin
      blank = 4'b0000;
      case (state_q)
         SET_H:   blank = {blink_phase, blink_phase, 2'b00};
         SET_MIN: blank = {2'b00, blink_phase, blink_phase};
         default: blank = 4'b0000;
      endcase
   end

   assign mode = state_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - scoreboard bench for time_set_ctrl against a time-of-day model
module tb_time_set_ctrl;
   localparam int CLK_DIV = 4;

   logic       clk_in = 1'b0;
   logic       clk_run = 1'b1;
   logic       rst = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic [3:0] d0_min_out, d1_min_out, d0_h_out, d1_h_out, blank;
   logic [1:0] mode;

   time_set_ctrl #(.CLK_DIV(CLK_DIV)) dut (
      .clk_in     (clk_in),
      .rst        (rst),
      .btn_mode   (btn_mode),
      .btn_inc    (btn_inc),
      .d0_min_out (d0_min_out),
      .d1_min_out (d1_min_out),
      .d0_h_out   (d0_h_out),
      .d1_h_out   (d1_h_out),
      .blank      (blank),
      .mode       (mode)
   );

   always begin
      #5;
      if (clk_run) clk_in = ~clk_in;
   end

   typedef struct {
      logic [21:0] v;
      string       tag;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   failures = 0;

   // Reference model: plain hours/minutes/seconds integers and a prescaler phase.
   int h, m, s, div, md;

   logic [21:0] dut_vec;
   assign dut_vec = {mode, blank, d1_h_out, d0_h_out, d1_min_out, d0_min_out};

   function automatic void model_reset();
      h = 0; m = 0; s = 0; div = 0; md = 0;
   endfunction

   function automatic void model_step(input logic mb, input logic ib);
      if (md == 0 && div == CLK_DIV - 1) begin
         s = s + 1;
         if (s == 60) begin
            s = 0;
            m = m + 1;
            if (m == 60) begin
               m = 0;
               h = (h + 1) % 24;
            end
         end
      end
      if (ib && !mb && md == 1) h = (h + 1) % 24;
      if (ib && !mb && md == 2) m = (m + 1) % 60;
      div = (div + 1) % CLK_DIV;
      if (mb) begin
         if (md == 2) begin
            md = 0; s = 0; div = 0;
         end else begin
            md = md + 1;
         end
      end
   endfunction

   function automatic logic [21:0] model_out();
      logic       bp;
      logic [3:0] bl;
      bp = (div >= CLK_DIV / 2);
      bl = 4'b0000;
      if (md == 1) bl = {bp, bp, 2'b00};
      if (md == 2) bl = {2'b00, bp, bp};
      return {2'(md), bl, 4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
   endfunction

   task automatic step(input logic mb, input logic ib, input string tag);
      btn_mode = mb;
      btn_inc  = ib;
      @(posedge clk_in);
      model_step(mb, ib);
      sb_q.push_back('{v: model_out(), tag: tag});
      #1;
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
   endtask

   always @(negedge clk_in) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         checks++;
         if (dut_vec !== e.v) begin
            failures++;
            $display("FAIL %s: got mode/blank/hhmm=%h expected %h at %0t", e.tag, dut_vec, e.v, $time);
         end
      end
   end

   initial begin
      int guard;
      #2 rst = 1'b1;
      #1;
      checks++;
      if (dut_vec !== 22'h0) begin
         failures++;
         $display("FAIL reset_state: got %h expected %h", dut_vec, 22'h0);
      end
      repeat (2) @(posedge clk_in);
      #1 rst = 1'b0;
      model_reset();

      for (int i = 0; i < 480; i++) step(1'b0, 1'b0, "free_run");

      step(1'b1, 1'b0, "enter_set_h");
      for (int i = 0; i < 25; i++) step(1'b0, 1'b1, "hour_wrap");
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, "set_h_blink");

      guard = 0;
      while (h != 23 && guard < 30) begin
         step(1'b0, 1'b1, "hours_to_23");
         guard++;
      end
      step(1'b1, 1'b1, "mode_inc_simul");
      guard = 0;
      while (m != 59 && guard < 70) begin
         step(1'b0, 1'b1, "minutes_to_59");
         guard++;
      end
      step(1'b0, 1'b1, "minute_wrap");
      guard = 0;
      while (m != 59 && guard < 70) begin
         step(1'b0, 1'b1, "minutes_back_59");
         guard++;
      end
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, "set_min_blink");
      step(1'b1, 1'b0, "exit_to_run");
      for (int i = 0; i < 244; i++) step(1'b0, 1'b1, "day_wrap_inc_ignored");

      step(1'b1, 1'b0, "freeze_set_h");
      step(1'b1, 1'b0, "freeze_set_min");
      for (int i = 0; i < 1000; i++) step(1'b0, 1'b0, "freeze_hold");
      step(1'b1, 1'b0, "freeze_exit");
      for (int i = 0; i < 250; i++) step(1'b0, 1'b0, "first_full_minute");

      for (int i = 0; i < 1500; i++) begin
         int r;
         r = $urandom_range(0, 99);
         step(r < 4, (r >= 2 && r < 35), "random");
      end

      guard = 0;
      while (md != 1 && guard < 4) begin
         step(1'b1, 1'b0, "goto_set_h");
         guard++;
      end
      guard = 0;
      while (div < CLK_DIV / 2 && guard < CLK_DIV) begin
         step(1'b0, 1'b1, "before_async_reset");
         guard++;
      end
      @(negedge clk_in);
      #1 clk_run = 1'b0;
      #20 rst = 1'b1;
      #1;
      checks++;
      if (dut_vec !== 22'h0) begin
         failures++;
         $display("FAIL async_reset_no_clock: got %h expected %h", dut_vec, 22'h0);
      end
      #10 clk_run = 1'b1;
      repeat (2) @(posedge clk_in);
      #1 rst = 1'b0;
      model_reset();
      for (int i = 0; i < 250; i++) step(1'b0, 1'b0, "run_after_reset");

      for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk_in);
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending expected 0", sb_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
